// File: rtl/dispensador_pkg.sv
// Shared constants, state encodings and sizing helpers for the note/card dispenser.
package dispensador_pkg;

  localparam int PAG_W            = 4;
  localparam int NOTE_CYCLES_DEF  = 8;
  localparam int JAM_CYCLES_DEF   = 32;
  localparam int CARD_CYCLES_DEF  = 16;

  localparam int STATE_W = 3;
  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_IDLE        = 3'd0;
  localparam state_t ST_FEED        = 3'd1;
  localparam state_t ST_WAIT_SENSOR = 3'd2;
  localparam state_t ST_DONE        = 3'd3;
  localparam state_t ST_CARD        = 3'd4;
  localparam state_t ST_JAM         = 3'd5;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  // The timer is loaded with (cycles - 1), so it only needs to hold max-1.
  function automatic int timer_width(input int a, input int b, input int c);
    int m;
    m = max3(a, b, c);
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/dispensador_notas_temporizador.sv
// Loadable down-counter with a zero flag; load wins over decrement, stops at zero.
module temporizador_descendente #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/dispensador_notas.sv
// Note-feed and card-eject actuator: dispenses a requested note count one note at a
// time with exit-sensor confirmation, services card return/retain, flags jams.
module dispensador_notas
  import dispensador_pkg::*;
#(
  parameter int NOTE_CYCLES = NOTE_CYCLES_DEF,
  parameter int JAM_CYCLES  = JAM_CYCLES_DEF,
  parameter int CARD_CYCLES = CARD_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PAG_W-1:0] pag,
  input  logic             pagValid,
  output logic             pagReady,
  input  logic             ejetaTentativa,
  input  logic             ejetaTempo,
  input  logic             notaSensor,
  output logic             notaMotor,
  output logic             cartaoEjeta,
  output logic             cartaoRetido,
  output logic [PAG_W-1:0] dispensado,
  output logic             done,
  output logic             erroJam
);

  localparam int TW = timer_width(NOTE_CYCLES, JAM_CYCLES, CARD_CYCLES);
  localparam logic [TW-1:0] NOTE_LOAD = TW'(NOTE_CYCLES - 1);
  localparam logic [TW-1:0] JAM_LOAD  = TW'(JAM_CYCLES - 1);
  localparam logic [TW-1:0] CARD_LOAD = TW'(CARD_CYCLES - 1);

  state_t             state_q,    state_d;
  logic [PAG_W-1:0]   restante_q, restante_d;
  logic [PAG_W-1:0]   disp_q,     disp_d;
  logic               retido_q,   retido_d;
  logic               pend_ret_q, pend_ret_d;
  logic               pend_tmp_q, pend_tmp_d;

  logic               tmr_load;
  logic [TW-1:0]      tmr_val;
  logic               tmr_dec;
  logic               tmr_zero;
  logic               card_req;

  temporizador_descendente #(.W(TW)) u_tmr (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .dec_i      (tmr_dec),
    .zero_o     (tmr_zero)
  );

  // A request still on the inputs this cycle counts as pending, so IDLE reacts at once.
  assign card_req = pend_ret_q | pend_tmp_q | ejetaTentativa | ejetaTempo;

  always_comb begin
    state_d    = state_q;
    restante_d = restante_q;
    disp_d     = disp_q;
    retido_d   = retido_q;
    pend_ret_d = pend_ret_q;
    pend_tmp_d = pend_tmp_q;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    tmr_dec    = 1'b0;

    if (state_q != ST_JAM) begin
      pend_ret_d = pend_ret_q | ejetaTentativa;
      pend_tmp_d = pend_tmp_q | ejetaTempo;
    end

    case (state_q)
      ST_IDLE: begin
        if (card_req) begin
          state_d  = ST_CARD;
          retido_d = pend_ret_q | ejetaTentativa;
          tmr_load = 1'b1;
          tmr_val  = CARD_LOAD;
        end else if (pagValid) begin
          restante_d = pag;
          disp_d     = '0;
          if (pag != '0) begin
            state_d  = ST_FEED;
            tmr_load = 1'b1;
            tmr_val  = NOTE_LOAD;
          end else begin
            state_d = ST_DONE;
          end
        end
      end

      ST_FEED: begin
        if (tmr_zero) begin
          state_d  = ST_WAIT_SENSOR;
          tmr_load = 1'b1;
          tmr_val  = JAM_LOAD;
        end else begin
          tmr_dec = 1'b1;
        end
      end

      ST_WAIT_SENSOR: begin
        // Leaving the state on the first pulse guarantees one credit per visit.
        if (notaSensor) begin
          disp_d     = disp_q + PAG_W'(1);
          restante_d = restante_q - PAG_W'(1);
          if (restante_q == PAG_W'(1)) begin
            state_d = ST_DONE;
          end else begin
            state_d  = ST_FEED;
            tmr_load = 1'b1;
            tmr_val  = NOTE_LOAD;
          end
        end else if (tmr_zero) begin
          state_d = ST_JAM;
        end else begin
          tmr_dec = 1'b1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      ST_CARD: begin
        if (tmr_zero) begin
          state_d    = ST_IDLE;
          pend_ret_d = 1'b0;
          pend_tmp_d = 1'b0;
        end else begin
          tmr_dec = 1'b1;
        end
      end

      ST_JAM: begin
        state_d = ST_JAM;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      restante_q <= '0;
      disp_q     <= '0;
      retido_q   <= 1'b0;
      pend_ret_q <= 1'b0;
      pend_tmp_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      restante_q <= restante_d;
      disp_q     <= disp_d;
      retido_q   <= retido_d;
      pend_ret_q <= pend_ret_d;
      pend_tmp_q <= pend_tmp_d;
    end
  end

  assign pagReady     = (state_q == ST_IDLE) && !card_req;
  assign notaMotor    = (state_q == ST_FEED);
  assign cartaoEjeta  = (state_q == ST_CARD) && !retido_q;
  assign cartaoRetido = (state_q == ST_CARD) &&  retido_q;
  assign done         = (state_q == ST_DONE);
  assign erroJam      = (state_q == ST_JAM);
  assign dispensado   = disp_q;

endmodule

// File: doc/dispensador_notas.md
# dispensador_notas

Cash-and-card actuator responder on the output side of the ATM controller. It accepts a payout request (note count) from the controller's PAG outputs and drives the note-feed motor one note at a time, confirming each note with the exit sensor. It also services the controller's card-eject requests (ejetaTempo → return card, ejetaTentativa → retain card). It reports dispensed count, completion and jam status back to the controller.

## Interface
- NOTE_CYCLES, 8: cycles notaMotor stays high per note (≥1)
- JAM_CYCLES, 32: max cycles to wait for notaSensor after feed before declaring jam (≥1)
- CARD_CYCLES, 16: cycles cartaoEjeta/cartaoRetido stay high (≥1)
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- pag  in  4  requested note count (PAG4..PAG1, PAG4 = MSB), 0–15
- pagValid  in  1  request strobe; transfer when pagValid && pagReady
- pagReady  out  1  high only in IDLE with no card request pending or present
- ejetaTentativa  in  1  retain-card request (attempts exhausted), level, sampled per cycle
- ejetaTempo  in  1  return-card request (timeout), level, sampled per cycle
- notaSensor  in  1  exit sensor, one-cycle pulse per note delivered
- notaMotor  out  1  feed motor drive
- cartaoEjeta  out  1  card-return motor drive
- cartaoRetido  out  1  card-capture motor drive
- dispensado  out  4  notes confirmed in current/last request
- done  out  1  one-cycle pulse at request completion
- erroJam  out  1  sticky jam flag, cleared only by reset

## Operation
- States: IDLE, FEED, WAIT_SENSOR, DONE, CARD, JAM.
- Reset (rst_n low at an edge): state IDLE, all outputs 0 except pagReady=1; counters, pending-card flags cleared. Reset mid-dispense or mid-card abandons the operation; no done pulse.
- IDLE: if a card request is pending or present, go to CARD (priority over pag). Else on pagValid&&pagReady: latch restante=pag, clear dispensado; pag≠0 → FEED, pag=0 → DONE.
- FEED: notaMotor=1 for exactly NOTE_CYCLES cycles, then WAIT_SENSOR.
- WAIT_SENSOR: notaMotor=0. notaSensor=1 → dispensado+1, restante−1; restante reaches 0 → DONE, else FEED. No pulse within JAM_CYCLES cycles → JAM.
- notaSensor outside WAIT_SENSOR is ignored; at most one note credited per WAIT_SENSOR visit.
- DONE: done=1 for one cycle, then IDLE. dispensado holds until the next accepted request.
- JAM: erroJam=1, all motors off, pagReady=0; exits only via reset.
- Card requests: ejetaTentativa/ejetaTempo are latched into pending flags in any non-JAM state and serviced on the next IDLE. Both set → retain wins (cartaoRetido); the other flag is discarded.
- CARD: drive the selected motor for CARD_CYCLES cycles, clear both pending flags, then IDLE.
- Arithmetic: 4-bit unsigned, no wrap possible (dispensado ≤ pag ≤ 15).

## Timing
- Request accepted at edge k → notaMotor high in cycles k+1..k+NOTE_CYCLES.
- Sensor pulse sampled at edge m → dispensado updated at m; next FEED (or done) from cycle m+1.
- Minimum per-note time: NOTE_CYCLES+1 cycles. pag=0 → done at cycle k+1.
- Card request seen at edge k in IDLE → motor high cycles k+1..k+CARD_CYCLES; pagReady low from cycle k+1 (combinational on request input during cycle k).
- Jam declared at the JAM_CYCLES-th edge of WAIT_SENSOR without sensor; erroJam high from the next cycle.

## Structure
- Package dispensador_pkg: state enum, width constant PAG_W=4, default cycle constants.
- One sub-module: temporizador_descendente (loadable down-counter with zero flag), one instance shared by FEED/WAIT_SENSOR/CARD timing.

## Test plan
- Reset, pag=3 with pagValid, sensor pulse 2 cycles into each WAIT_SENSOR → three 8-cycle motor bursts, dispensado=3, one done pulse.
- pag=0 request → no motor activity, done one cycle after accept, dispensado=0.
- pag=2, no sensor after first feed → JAM after 32 cycles, erroJam=1, pagReady=0 until rst_n low.
- ejetaTempo pulse during pag=2 dispense → dispense completes, then cartaoEjeta high 16 cycles, pagReady low throughout.
- ejetaTentativa and ejetaTempo together in IDLE with pagValid → cartaoRetido 16 cycles, cartaoEjeta stays 0, pag accepted only afterwards.
- rst_n low during second note of pag=4 → all outputs reset next cycle, no done pulse.
